// File: rtl/scan_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_cfg_pkg
// Description : Shared definitions for the overlay scan-chain loader: loader
//               FSM state encoding, bit-order constant and the default chain
//               length of a 125-input crossbar (31 SHIFTREG32 LUTs x 32).
// Revision    : 1.0 - initial release
// ============================================================================
package scan_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } scan_state_t;

    // Configuration words are serialised bit 0 first.
    localparam bit SCAN_LSB_FIRST = 1'b1;

    // 31 LUTs x 32 bits for a 125-input crossbar.
    localparam int SCAN_XBAR_CHAIN_LEN = 992;

endpackage : scan_cfg_pkg
`default_nettype wire

// File: rtl/scan_readback_packer.sv
`default_nettype none
// ============================================================================
// Module      : scan_readback_packer
// Description : Packs the scan chain's SOUT stream into WORD_W-bit readback
//               words, LSB first. A word is emitted after every WORD_W
//               captured bits, and a final partial word is flushed (upper bits
//               zero) on the last shift of a load.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               capture         - SE as presented to the chain this cycle
//               bit_in          - SOUT from the end of the chain
//               last            - this capture is the final shift of the load
//               dout            - readback word (held until the next word)
//               dout_valid      - one-cycle strobe, cycle after the word fills
// Revision    : 1.0 - initial release
// ============================================================================
module scan_readback_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              bit_in,
    input  logic              last,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] r_dout;
    logic              r_dout_valid;
    logic [WORD_W-1:0] w_word;
    logic              w_word_full;

    // Word including the bit being captured this cycle.
    always_comb begin
        w_word      = r_buf | (WORD_W'(bit_in) << r_idx);
        w_word_full = (32'(r_idx) == WORD_W - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_buf        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (capture) begin
                if (w_word_full || last) begin
                    // Buffer is cleared on emit, so a flushed partial word
                    // carries zeros in its unused upper bits.
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
                    r_buf        <= '0;
                    r_idx        <= '0;
                end else begin
                    r_buf <= w_word;
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule : scan_readback_packer
`default_nettype wire

// File: rtl/scan_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_loader
// Description : Serialises configuration words received over valid/ready onto
//               an overlay LUT scan chain (SIN/SE) for exactly CHAIN_LEN shift
//               cycles. With SCAN_READBACK_EN defined, the chain's SOUT stream
//               is captured and returned as DOUT/DOUT_VALID words.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start               - begin a load (sampled in IDLE only)
//               din/din_valid/din_ready - configuration word handshake
//               se, sin             - registered scan enable / scan data
//               sout                - scan output from the end of the chain
//               busy                - load in progress
//               done                - one-cycle pulse after the final shift
//               dout, dout_valid    - readback (SCAN_READBACK_EN only)
// Macros      : SCAN_READBACK_EN - enables SOUT capture and readback ports
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_loader
    import scan_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_XBAR_CHAIN_LEN,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              se,
    output logic              sin,
    input  logic              sout,
    output logic              busy,
    output logic              done
`ifdef SCAN_READBACK_EN
    ,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [BIT_W-1:0]   r_bits_left;
    logic [BIT_W-1:0]   w_word_bits;
    logic [WORD_W-1:0]  r_shreg;
    logic               r_se;
    logic               r_sin;
    logic               w_accept;
    logic               w_word_end;
    logic               w_final;

    always_comb begin
        w_accept   = (r_state == ST_LOAD) && din_valid;
        w_word_end = (r_state == ST_SHIFT) && (r_bits_left == BIT_W'(1));
        // remaining never drops below bits_left, so the final shift of the
        // load is always also the last shift of its word.
        w_final    = (r_state == ST_SHIFT) && (r_remaining == CNT_W'(1));
        // Shifts for the next word: min(WORD_W, remaining).
        w_word_bits = BIT_W'(WORD_W);
        if (32'(r_remaining) < WORD_W) begin
            w_word_bits = BIT_W'(r_remaining);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_state_next = ST_LOAD;
            ST_LOAD:  if (din_valid) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_word_end) w_state_next = w_final ? ST_FIN : ST_LOAD;
            ST_FIN:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serialiser. SE/SIN are registered: the bit shown during a SHIFT
    // cycle was loaded on the previous edge, so the handshake edge itself
    // presents DIN[0].
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_bits_left <= '0;
            r_shreg     <= '0;
            r_se        <= 1'b0;
            r_sin       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_remaining <= CNT_W'(CHAIN_LEN);
            end
            if (w_accept) begin
                r_shreg     <= din >> 1;
                r_sin       <= din[0];
                r_se        <= 1'b1;
                r_bits_left <= w_word_bits;
            end else if (r_state == ST_SHIFT) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_bits_left <= r_bits_left - BIT_W'(1);
                if (w_word_end) begin
                    // Unshifted upper bits of a final partial word are dropped.
                    r_se  <= 1'b0;
                    r_sin <= 1'b0;
                end else begin
                    r_sin   <= r_shreg[0];
                    r_shreg <= r_shreg >> 1;
                end
            end
        end
    end

    assign se        = r_se;
    assign sin       = r_sin;
    assign din_ready = (r_state == ST_LOAD);
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign done      = (r_state == ST_FIN);

`ifdef SCAN_READBACK_EN
    scan_readback_packer #(
        .WORD_W     (WORD_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (r_se),
        .bit_in     (sout),
        .last       (w_final),
        .dout       (dout),
        .dout_valid (dout_valid)
    );
`else
    logic w_unused_sout;
    assign w_unused_sout = sout;
`endif

endmodule : scan_chain_loader
`default_nettype wire

// File: tb/tb_scan_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_chain_loader
// Description : Self-checking bench for scan_chain_loader. DUT A uses a 40-bit
//               chain (with a behavioural scan chain on SIN/SE/SOUT), DUT C a
//               1-bit chain. Expected SIN streams, SE run lengths, chain
//               contents and readback words are derived from the loaded words.
// Macros      : SCAN_READBACK_EN - also checks DOUT/DOUT_VALID
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_loader;

    localparam int LA = 40;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A (40-bit chain)
    logic          start_a, din_valid_a, din_ready_a, se_a, sin_a, sout_a, busy_a, done_a;
    logic [W-1:0]  din_a;
    // DUT C (1-bit chain)
    logic          start_c, din_valid_c, din_ready_c, se_c, sin_c, sout_c, busy_c, done_c;
    logic [W-1:0]  din_c;
    assign sout_c = 1'b0;
`ifdef SCAN_READBACK_EN
    logic [W-1:0]  dout_a, dout_c;
    logic          dout_valid_a, dout_valid_c;
`endif

    scan_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .se(se_a), .sin(sin_a), .sout(sout_a), .busy(busy_a),
        .done(done_a)
`ifdef SCAN_READBACK_EN
        , .dout(dout_a), .dout_valid(dout_valid_a)
`endif
    );

    scan_chain_loader #(.CHAIN_LEN(1), .WORD_W(W)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .din(din_c), .din_valid(din_valid_c),
        .din_ready(din_ready_c), .se(se_c), .sin(sin_c), .sout(sout_c), .busy(busy_c),
        .done(done_c)
`ifdef SCAN_READBACK_EN
        , .dout(dout_c), .dout_valid(dout_valid_c)
`endif
    );

    // Behavioural 40-bit scan chain: SIN enters at the top, SOUT leaves bit 0.
    logic [LA-1:0] chain;
    logic [LA-1:0] pre_val;
    logic          pre_req = 1'b0;
    assign sout_a = chain[0];
    always @(posedge clk) begin
        if (pre_req)   chain <= pre_val;
        else if (se_a) chain <= {sin_a, chain[LA-1:1]};
    end

    // Monitor for DUT A, sampled mid-cycle.
    logic [W-1:0] words[$];
    bit           sin_q[$];
    int           runs[$];
    int           se_cnt, run_len, done_cnt, overlap, stall_se;
    bit           stall_flag = 1'b0;
`ifdef SCAN_READBACK_EN
    logic [W-1:0] rb_q[$];
    bit           rb_done[$];
`endif
    always @(negedge clk) begin
        if (se_a) begin
            sin_q.push_back(sin_a);
            se_cnt++;
            run_len++;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (done_a) done_cnt++;
        if (se_a && din_ready_a) overlap++;
        if (stall_flag && se_a) stall_se++;
`ifdef SCAN_READBACK_EN
        if (dout_valid_a) begin
            rb_q.push_back(dout_a);
            rb_done.push_back(done_a);
        end
`endif
    end

    function automatic bit exp_bit(input int i);
        logic [W-1:0] wd;
        wd = words[i / W];
        return wd[i % W];
    endfunction

    task automatic preload_chain(input logic [LA-1:0] v);
        pre_val = v;
        pre_req = 1'b1;
        @(posedge clk); #1;
        pre_req = 1'b0;
    endtask

    // One full load on DUT A using the words queue. stall: cycles to withhold
    // DIN_VALID in the first LOAD; disturb: pulse START and hold junk DIN_VALID
    // while shifting.
    task automatic run_load(input int stall, input bit disturb);
        int            nw, rem, nb, hs, cyc, errs;
        int            exp_runs[$];
        logic [LA-1:0] old_chain, exp_chain;
        nw = (LA + W - 1) / W;
        old_chain = chain;
        sin_q.delete(); runs.delete();
        se_cnt = 0; run_len = 0; done_cnt = 0; overlap = 0; stall_se = 0;
`ifdef SCAN_READBACK_EN
        rb_q.delete(); rb_done.delete();
`endif
        nb = 0; hs = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || din_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL start_response: busy=%b din_ready=%b, expected 1 1", busy_a, din_ready_a);
        end
        rem = LA;
        for (int wi = 0; wi < nw; wi++) begin
            cyc = 0;
            while (din_ready_a !== 1'b1 && cyc < 200) begin
                @(posedge clk); #1; cyc++;
            end
            if (wi > 0) begin
                n_checks++;
                if (din_ready_a !== 1'b1 || cycle != hs + 1 + nb) begin
                    n_fail++;
                    $display("FAIL reload_ready: din_ready=%b at cycle %0d, expected 1 at %0d",
                             din_ready_a, cycle, hs + 1 + nb);
                end
            end
            if (stall > 0 && wi == 0) begin
                din_valid_a = 1'b0;
                stall_flag = 1'b1;
                repeat (stall) begin @(posedge clk); #1; end
                stall_flag = 1'b0;
                n_checks++;
                if (din_ready_a !== 1'b1 || se_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold: din_ready=%b se=%b, expected 1 0", din_ready_a, se_a);
                end
            end
            din_a = words[wi];
            din_valid_a = 1'b1;
            @(posedge clk); #1;
            hs = cycle - 1;
            din_valid_a = disturb;
            din_a = $urandom;
            n_checks++;
            if (se_a !== 1'b1 || sin_a !== words[wi][0]) begin
                n_fail++;
                $display("FAIL first_shift: se=%b sin=%b, expected 1 %b", se_a, sin_a, words[wi][0]);
            end
            nb = (rem < W) ? rem : W;
            rem -= nb;
            exp_runs.push_back(nb);
            if (disturb && wi == 0) begin
                start_a = 1'b1;
                @(posedge clk); #1;
                start_a = 1'b0;
                n_checks++;
                if (busy_a !== 1'b1 || se_a !== 1'b1 || din_ready_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_ignored: busy=%b se=%b din_ready=%b, expected 1 1 0",
                             busy_a, se_a, din_ready_a);
                end
            end
        end
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (done_a !== 1'b1 || cycle != hs + 1 + nb) begin
            n_fail++;
            $display("FAIL done_timing: done=%b at cycle %0d, expected 1 at %0d", done_a, cycle, hs + 1 + nb);
        end
        @(posedge clk); #1;
        din_valid_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || din_ready_a !== 1'b0 || se_a !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: done=%b busy=%b din_ready=%b se=%b, expected 0 0 0 0",
                     done_a, busy_a, din_ready_a, se_a);
        end
        @(posedge clk); #1;

        errs = 0;
        for (int i = 0; i < LA && i < sin_q.size(); i++) if (sin_q[i] != exp_bit(i)) errs++;
        n_checks++;
        if (sin_q.size() != LA || errs != 0) begin
            n_fail++;
            $display("FAIL sin_stream: %0d bits with %0d errors, expected %0d bits with 0 errors",
                     sin_q.size(), errs, LA);
        end
        n_checks++;
        if (se_cnt != LA || runs != exp_runs) begin
            n_fail++;
            $display("FAIL se_runs: total=%0d runs=%p, expected total=%0d runs=%p", se_cnt, runs, LA, exp_runs);
        end
        n_checks++;
        if (done_cnt != 1 || overlap != 0 || stall_se != 0) begin
            n_fail++;
            $display("FAIL pulse_counts: done=%0d overlap=%0d stall_se=%0d, expected 1 0 0",
                     done_cnt, overlap, stall_se);
        end
        for (int i = 0; i < LA; i++) exp_chain[i] = exp_bit(i);
        n_checks++;
        if (chain !== exp_chain) begin
            n_fail++;
            $display("FAIL chain_contents: got %h, expected %h", chain, exp_chain);
        end
`ifdef SCAN_READBACK_EN
        begin
            logic [W-1:0] exp_rb[$];
            logic [W-1:0] wd;
            for (int i = 0; i < LA; i += W) begin
                wd = '0;
                for (int b = 0; b < W && i + b < LA; b++) wd[b] = old_chain[i + b];
                exp_rb.push_back(wd);
            end
            n_checks++;
            if (rb_q != exp_rb || rb_done.size() == 0 || rb_done[rb_done.size() - 1] != 1'b1) begin
                n_fail++;
                $display("FAIL readback: got %p, expected %p (last with DONE)", rb_q, exp_rb);
            end
        end
`else
        if (old_chain === exp_chain) begin end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; din_valid_a = 0; din_a = '0;
        start_c = 0; din_valid_c = 0; din_c = '0;
        preload_chain('0);
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if ({se_a, sin_a, din_ready_a, busy_a, done_a, se_c, sin_c, din_ready_c, busy_c, done_c} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: A se/sin/rdy/busy/done=%b%b%b%b%b C=%b%b%b%b%b, expected all 0",
                     se_a, sin_a, din_ready_a, busy_a, done_a, se_c, sin_c, din_ready_c, busy_c, done_c);
        end
`ifdef SCAN_READBACK_EN
        n_checks++;
        if (dout_a !== '0 || dout_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_readback: dout=%h valid=%b, expected 0 0", dout_a, dout_valid_a);
        end
`endif
        // DIN_VALID in IDLE must not be consumed.
        din_a = $urandom; din_valid_a = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (din_ready_a !== 1'b0 || busy_a !== 1'b0 || se_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: din_ready=%b busy=%b se=%b, expected 0 0 0",
                     din_ready_a, busy_a, se_a);
        end
        din_valid_a = 1'b0;
    endtask

    task automatic test_basic();
        words.delete();
        words.push_back(32'hA5A5_0F0F);
        words.push_back(32'h0000_00C3);
        run_load(0, 1'b0);
    endtask

    task automatic test_partial_discard();
        words.delete();
        words.push_back(32'h1357_9BDF);
        words.push_back(32'hFFFF_FF3C);
        run_load(0, 1'b0);
    endtask

    task automatic test_stall();
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_load(10, 1'b0);
    endtask

    task automatic test_start_ignored();
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_load(0, 1'b1);
    endtask

    task automatic test_random_loads();
        for (int n = 0; n < 3; n++) begin
            words.delete();
            words.push_back($urandom);
            words.push_back($urandom);
            run_load(n, 1'b0);
        end
    endtask

`ifdef SCAN_READBACK_EN
    task automatic test_readback();
        preload_chain(40'h12_3456_789A);
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_load(0, 1'b0);
        n_checks++;
        if (rb_q.size() != 2 || rb_q[0] !== 32'h3456_789A || rb_q[1] !== 32'h0000_0012) begin
            n_fail++;
            $display("FAIL readback_known: got %p, expected 3456789a 00000012", rb_q);
        end
    endtask
`endif

    task automatic test_reset_mid_shift();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        din_a = $urandom; din_valid_a = 1'b1;
        @(posedge clk); #1;
        din_valid_a = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (se_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_pre: se=%b busy=%b, expected 1 1", se_a, busy_a);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (se_a !== 1'b0 || sin_a !== 1'b0 || busy_a !== 1'b0 || din_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: se=%b sin=%b busy=%b din_ready=%b, expected 0 0 0 0",
                     se_a, sin_a, busy_a, din_ready_a);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (se_a !== 1'b0 || busy_a !== 1'b0 || din_ready_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle: se=%b busy=%b din_ready=%b done=%b, expected 0 0 0 0",
                     se_a, busy_a, din_ready_a, done_a);
        end
        // Full reload after the interrupted one.
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_load(0, 1'b0);
    endtask

    task automatic test_chain_len_one(input logic [W-1:0] d);
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        n_checks++;
        if (busy_c !== 1'b1 || din_ready_c !== 1'b1) begin
            n_fail++;
            $display("FAIL len1_start: busy=%b din_ready=%b, expected 1 1", busy_c, din_ready_c);
        end
        din_c = d; din_valid_c = 1'b1;
        @(posedge clk); #1;
        din_valid_c = 1'b0;
        n_checks++;
        if (se_c !== 1'b1 || sin_c !== d[0] || done_c !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_shift: se=%b sin=%b done=%b, expected 1 %b 0", se_c, sin_c, done_c, d[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (se_c !== 1'b0 || sin_c !== 1'b0 || done_c !== 1'b1 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_done: se=%b sin=%b done=%b busy=%b, expected 0 0 1 0",
                     se_c, sin_c, done_c, busy_c);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_c !== 1'b0 || din_ready_c !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_idle: done=%b din_ready=%b, expected 0 0", done_c, din_ready_c);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        test_reset();
        test_basic();
        test_partial_discard();
        test_stall();
        test_start_ignored();
        test_random_loads();
`ifdef SCAN_READBACK_EN
        test_readback();
`endif
        test_reset_mid_shift();
        d = $urandom;
        test_chain_len_one({d[W-1:1], 1'b1});
        test_chain_len_one({d[W-1:1], 1'b0});
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_scan_chain_loader
`default_nettype wire
